// File: rtl/encr_payload_framer.sv
// encr_payload_framer
// Reads the encryption payload FIFO in the payload slots of a programmable
// frame (overhead slots first, then payload). It emits a registered, framed
// word stream and keeps running between start-of-frame pulses. It also counts
// resyncs and frames that ended without a start-of-frame pulse.
// Optional build macro ENCR_PAYLOAD_FRAMER_LEVEL_CHECK_EN adds a counter that
// records frame starts where the FIFO fill level was below a threshold.
module encr_payload_framer #(
  parameter int NB_DATA    = 256,
  parameter int NB_ADRESS  = 3,
  parameter int NB_FRAME   = 10,
  parameter int NB_COUNTER = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_DATA-1:0]    i_data,
  input  logic [NB_ADRESS-1:0]  i_fifo_level,
  input  logic [NB_DATA-1:0]    i_oh_data,
  input  logic                  i_sof,
  input  logic                  i_rf_static_enable,
  input  logic [NB_FRAME-1:0]   i_rf_static_frame_words,
  input  logic [NB_FRAME-1:0]   i_rf_static_oh_words,
  input  logic [NB_ADRESS-1:0]  i_rf_static_level_thr,
  output logic                  o_stop_read,
  output logic [NB_DATA-1:0]    o_data,
  output logic                  o_valid,
  output logic                  o_sof,
  output logic                  o_is_oh,
  output logic [NB_COUNTER-1:0] o_rf_static_resync_counter,
  output logic [NB_COUNTER-1:0] o_rf_static_missed_sof_counter,
  output logic [NB_COUNTER-1:0] o_rf_static_level_alarm_counter
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OH      = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]            state;
  logic [NB_FRAME-1:0]   slot;
  logic [NB_COUNTER-1:0] resync_count;
  logic [NB_COUNTER-1:0] missed_sof_count;

  logic                  start;
  logic                  active;
  logic                  in_oh;
  logic [NB_FRAME-1:0]   cur_slot;
  logic                  frame_end;
  logic                  oh_end;
  logic                  resync;
  logic                  sof_slot;
  logic                  run;

  // A start pulse seen in IDLE makes the current cycle overhead slot 0, so the
  // first frame begins without an extra idle cycle.
  always_comb begin
    run       = !i_reset && i_rf_static_enable;
    start     = (state == ST_IDLE) && i_sof;
    active    = (state != ST_IDLE) || start;
    in_oh     = start || (state == ST_OH);
    cur_slot  = start ? '0 : slot;
    frame_end = (state != ST_IDLE) &&
                (slot == i_rf_static_frame_words - NB_FRAME'(1));
    oh_end    = in_oh && (cur_slot == i_rf_static_oh_words - NB_FRAME'(1));
    resync    = (state != ST_IDLE) && i_sof && !frame_end;
    sof_slot  = in_oh && (cur_slot == '0);
  end

  // FIFO read strobe follows the state with no latency; disabling the block
  // stops reads within the same cycle.
  assign o_stop_read = !(run && (state == ST_PAYLOAD));

  // Slot sequencing, flywheel/resync handling and the registered output word.
  always_ff @(posedge i_clock) begin
    if (!run) begin
      state            <= ST_IDLE;
      slot             <= '0;
      o_valid          <= 1'b0;
      o_sof            <= 1'b0;
      o_is_oh          <= 1'b0;
      o_data           <= '0;
      resync_count     <= '0;
      missed_sof_count <= '0;
    end else if (!active) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_is_oh <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= 1'b1;
      o_sof   <= sof_slot;
      o_is_oh <= in_oh;
      o_data  <= in_oh ? i_oh_data : i_data;
      if (frame_end) begin
        slot  <= '0;
        state <= ST_OH;
        if (!i_sof && (missed_sof_count != '1)) begin
          missed_sof_count <= missed_sof_count + NB_COUNTER'(1);
        end
      end else if (resync) begin
        slot  <= '0;
        state <= ST_OH;
        if (resync_count != '1) begin
          resync_count <= resync_count + NB_COUNTER'(1);
        end
      end else begin
        slot <= cur_slot + NB_FRAME'(1);
        if (oh_end) begin
          state <= ST_PAYLOAD;
        end else if (start) begin
          state <= ST_OH;
        end
      end
    end
  end

  assign o_rf_static_resync_counter     = resync_count;
  assign o_rf_static_missed_sof_counter = missed_sof_count;

`ifdef ENCR_PAYLOAD_FRAMER_LEVEL_CHECK_EN
  logic [NB_COUNTER-1:0] level_alarm_count;

  // Count frame starts where the FIFO holds fewer words than the threshold.
  always_ff @(posedge i_clock) begin
    if (!run) begin
      level_alarm_count <= '0;
    end else if (sof_slot && (i_fifo_level < i_rf_static_level_thr) &&
                 (level_alarm_count != '1)) begin
      level_alarm_count <= level_alarm_count + NB_COUNTER'(1);
    end
  end

  assign o_rf_static_level_alarm_counter = level_alarm_count;
`else
  logic unused_level;
  assign unused_level = ^{i_fifo_level, i_rf_static_level_thr};
  assign o_rf_static_level_alarm_counter = '0;
`endif

endmodule

// File: tb/tb_encr_payload_framer.sv
// Testbench for encr_payload_framer: table-driven framing vectors,
// hand-written corner sequences and randomized traffic checked against a
// slot-position reference model.
module tb_encr_payload_framer;

  logic         clock;
  logic         reset;
  logic [255:0] data;
  logic [2:0]   fifo_level;
  logic [255:0] oh_data;
  logic         sof;
  logic         en;
  logic [9:0]   fw;
  logic [9:0]   ohw;
  logic [2:0]   thr;
  logic         stop_read;
  logic [255:0] out_data;
  logic         out_valid;
  logic         out_sof;
  logic         out_is_oh;
  logic [15:0]  resync_cnt;
  logic [15:0]  missed_cnt;
  logic [15:0]  alarm_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state: frame position rather than FSM state
  bit           m_active;
  int           m_pos;
  int           m_miss;
  int           m_resync;
  int           m_alarm;
  bit           e_valid;
  bit           e_sof;
  bit           e_oh;
  logic [255:0] e_data;

  typedef struct {
    bit sof_in;
    bit stop;
    bit valid;
    bit osof;
    bit isoh;
  } vec_t;
  vec_t         tbl[20];
  int           tbl_idx = -1;
  logic [255:0] prev_data;

  encr_payload_framer dut (
    .i_clock                         (clock),
    .i_reset                         (reset),
    .i_data                          (data),
    .i_fifo_level                    (fifo_level),
    .i_oh_data                       (oh_data),
    .i_sof                           (sof),
    .i_rf_static_enable              (en),
    .i_rf_static_frame_words         (fw),
    .i_rf_static_oh_words            (ohw),
    .i_rf_static_level_thr           (thr),
    .o_stop_read                     (stop_read),
    .o_data                          (out_data),
    .o_valid                         (out_valid),
    .o_sof                           (out_sof),
    .o_is_oh                         (out_is_oh),
    .o_rf_static_resync_counter      (resync_cnt),
    .o_rf_static_missed_sof_counter  (missed_cnt),
    .o_rf_static_level_alarm_counter (alarm_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit modelStop();
    return !(!reset && en && m_active && (m_pos >= int'(ohw)));
  endfunction

  task automatic modelEmit(input int p);
    e_valid = 1'b1;
    e_oh    = (p < int'(ohw));
    e_sof   = (p == 0);
    e_data  = e_oh ? oh_data : data;
`ifdef ENCR_PAYLOAD_FRAMER_LEVEL_CHECK_EN
    if (p == 0 && fifo_level < thr) m_alarm = sat16(m_alarm + 1);
`endif
  endtask

  // advance the model by one clock using the inputs present at the edge
  task automatic modelUpdate();
    if (reset || !en) begin
      m_active = 1'b0; m_pos = 0;
      m_miss = 0; m_resync = 0; m_alarm = 0;
      e_valid = 1'b0; e_sof = 1'b0; e_oh = 1'b0; e_data = '0;
    end else if (!m_active) begin
      if (sof) begin
        modelEmit(0);
        m_active = 1'b1;
        m_pos    = 1;
      end else begin
        e_valid = 1'b0; e_sof = 1'b0; e_oh = 1'b0; e_data = '0;
      end
    end else begin
      modelEmit(m_pos);
      if (m_pos == int'(fw) - 1) begin
        m_pos = 0;
        if (!sof) m_miss = sat16(m_miss + 1);
      end else if (sof) begin
        m_pos    = 0;
        m_resync = sat16(m_resync + 1);
      end else begin
        m_pos++;
      end
    end
  endtask

  // one clock: check DUT against the model mid-cycle, then advance
  task automatic applyStimulus();
    @(negedge clock);
    checkOutput("stop_read", 256'(stop_read), 256'(modelStop()));
    checkOutput("valid",     256'(out_valid), 256'(e_valid));
    checkOutput("sof_out",   256'(out_sof),   256'(e_sof));
    checkOutput("is_oh",     256'(out_is_oh), 256'(e_oh));
    checkOutput("data",      out_data,        e_data);
    checkOutput("resync_cnt", 256'(resync_cnt), 256'(m_resync));
    checkOutput("missed_cnt", 256'(missed_cnt), 256'(m_miss));
    checkOutput("alarm_cnt",  256'(alarm_cnt),  256'(m_alarm));
    if (tbl_idx >= 0) begin
      checkOutput("tbl_stop",  256'(stop_read), 256'(tbl[tbl_idx].stop));
      checkOutput("tbl_valid", 256'(out_valid), 256'(tbl[tbl_idx].valid));
      checkOutput("tbl_sof",   256'(out_sof),   256'(tbl[tbl_idx].osof));
      checkOutput("tbl_is_oh", 256'(out_is_oh), 256'(tbl[tbl_idx].isoh));
      checkOutput("tbl_data", out_data,
                  tbl[tbl_idx].valid ? (tbl[tbl_idx].isoh ? oh_data : prev_data)
                                     : 256'd0);
    end
    @(posedge clock);
    modelUpdate();
    #1;
  endtask

  task automatic resetSeq(input logic [9:0] f, input logic [9:0] o);
    reset = 1'b1; en = 1'b1; sof = 1'b0; fw = f; ohw = o;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sof = 1'b0; data = '0; fifo_level = '0;
    oh_data = '0; fw = 10'd8; ohw = 10'd2; thr = 3'd0;
    m_active = 1'b0; m_pos = 0; m_miss = 0; m_resync = 0; m_alarm = 0;
    e_valid = 1'b0; e_sof = 1'b0; e_oh = 1'b0; e_data = '0;
    prev_data = '0;
    @(posedge clock);
    #1;

    for (int k = 0; k < 20; k++) begin
      tbl[k].sof_in = (k == 10);
      tbl[k].stop   = !(k >= 12 && k <= 17);
      tbl[k].valid  = (k >= 11);
      tbl[k].osof   = (k == 11) || (k == 19);
      tbl[k].isoh   = (k == 11) || (k == 12) || (k == 19);
    end

    // reset state
    oh_data = rand256();
    resetSeq(10'd8, 10'd2);
    checkOutput("rst_valid",  256'(out_valid), 256'd0);
    checkOutput("rst_data",   out_data, 256'd0);
    checkOutput("rst_missed", 256'(missed_cnt), 256'd0);

    // framing vectors
    for (int k = 0; k < 20; k++) begin
      tbl_idx = k;
      sof  = tbl[k].sof_in;
      data = rand256();
      applyStimulus();
      prev_data = data;
    end
    tbl_idx = -1;
    sof = 1'b0;

    // flywheel: one start pulse then three frames without one
    resetSeq(10'd8, 10'd2);
    sof = 1'b1; data = rand256(); applyStimulus(); sof = 1'b0;
    for (int i = 0; i < 23; i++) begin data = rand256(); applyStimulus(); end
    checkOutput("fly_missed", 256'(missed_cnt), 256'd3);

    // resync at slot 5
    resetSeq(10'd8, 10'd2);
    sof = 1'b1; applyStimulus(); sof = 1'b0;
    for (int i = 0; i < 4; i++) begin data = rand256(); applyStimulus(); end
    sof = 1'b1; data = rand256(); applyStimulus(); sof = 1'b0;
    checkOutput("rs_slot5_valid", 256'(out_valid), 256'd1);
    checkOutput("rs_slot5_is_oh", 256'(out_is_oh), 256'd0);
    checkOutput("rs_slot5_data",  out_data, data);
    checkOutput("rs_stop",        256'(stop_read), 256'd1);
    checkOutput("rs_count",       256'(resync_cnt), 256'd1);
    checkOutput("rs_missed",      256'(missed_cnt), 256'd0);
    applyStimulus();
    checkOutput("rs_sof_out", 256'(out_sof), 256'd1);

    // disable mid-payload at slot 4 of the second frame
    resetSeq(10'd8, 10'd2);
    sof = 1'b1; applyStimulus(); sof = 1'b0;
    for (int i = 0; i < 11; i++) begin data = rand256(); applyStimulus(); end
    checkOutput("dis_missed_before", 256'(missed_cnt), 256'd1);
    checkOutput("dis_stop_before",   256'(stop_read), 256'd0);
    en = 1'b0;
    #1;
    checkOutput("dis_stop_same", 256'(stop_read), 256'd1);
    applyStimulus();
    checkOutput("dis_valid",  256'(out_valid), 256'd0);
    checkOutput("dis_missed", 256'(missed_cnt), 256'd0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("reen_idle_valid", 256'(out_valid), 256'd0);
    sof = 1'b1; applyStimulus(); sof = 1'b0;
    checkOutput("reen_sof_out", 256'(out_sof), 256'd1);

    // saturation of the missed-SOF counter near all-ones
    resetSeq(10'd2, 10'd1);
    sof = 1'b1; applyStimulus(); sof = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();
    force dut.missed_sof_count = 16'hFFFC;
    #1;
    release dut.missed_sof_count;
    m_miss = 65532;
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("sat_missed", 256'(missed_cnt), 256'hFFFF);

    // level alarm at frame starts (levels 3, 3, 5 against threshold 4)
    resetSeq(10'd8, 10'd2);
    thr = 3'd4;
    for (int c = 0; c < 17; c++) begin
      sof = (c == 0);
      fifo_level = (c == 0 || c == 8) ? 3'd3 : ((c == 16) ? 3'd5 : 3'd7);
      applyStimulus();
    end
    sof = 1'b0;
`ifdef ENCR_PAYLOAD_FRAMER_LEVEL_CHECK_EN
    checkOutput("alarm_count", 256'(alarm_cnt), 256'd2);
`else
    checkOutput("alarm_count", 256'(alarm_cnt), 256'd0);
`endif

    // randomized traffic
    for (int r = 0; r < 6; r++) begin
      en = 1'b0;
      applyStimulus();
      fw  = 10'($urandom_range(2, 20));
      ohw = 10'($urandom_range(1, int'(fw) - 1));
      thr = 3'($urandom_range(0, 7));
      en  = 1'b1;
      for (int c = 0; c < 400; c++) begin
        sof        = ($urandom_range(0, 15) == 0);
        en         = ($urandom_range(0, 99) != 0);
        reset      = ($urandom_range(0, 199) == 0);
        data       = rand256();
        oh_data    = rand256();
        fifo_level = 3'($urandom_range(0, 7));
        applyStimulus();
      end
      reset = 1'b0;
      sof   = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
